// File: rtl/get_ctrl_nd_pkg.sv
// get_pkg: shared defaults, state encoding and slicing helper for the
// N-dimensional get-path address sequencer (get_ctrl_nd / loop_cnt).
package get_pkg;

  localparam int GET_W    = 20;
  localparam int GET_DIMS = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } get_state_e;

  // Low bit of dim d in a flat DIMS*W vector (dim d lives at [d*W +: W]).
  function automatic int unsigned slice_lo(input int unsigned d, input int unsigned w);
    return d * w;
  endfunction

endpackage

// File: rtl/get_ctrl_nd_loop_cnt.sv
// loop_cnt: one dimension of the nested-loop sequencer.
//   clk, rst   : clock, synchronous active-high reset
//   clr        : force value to 0 (new sweep)
//   inc        : advance by step, wrapping to 0 when already last
//   bound      : inclusive upper bound
//   step       : increment (never 0 when inc is used)
//   value      : current index
//   last       : value + step would exceed bound
module loop_cnt #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] bound,
  input  logic [W-1:0] step,
  output logic [W-1:0] value,
  output logic         last
);

  logic [W-1:0] r_value;
  logic [W:0]   w_sum;

  // Extra carry bit so a bound of 2^W-1 never wraps the comparison.
  assign w_sum = {1'b0, r_value} + {1'b0, step};
  assign last  = (w_sum > {1'b0, bound});
  assign value = r_value;

  always_ff @(posedge clk) begin
    if (rst || clr)
      r_value <= '0;
    else if (inc)
      r_value <= last ? '0 : w_sum[W-1:0];
  end

endmodule

// File: rtl/get_ctrl_nd.sv
// get_ctrl_nd: DIMS-level nested-loop index sequencer for the get path.
// Emits one index tuple per accepted beat (valid/ready) and a one-cycle
// done pulse after the final tuple is accepted.
//   clk, rst   : clock, synchronous active-high reset
//   start      : begin a sweep (ignored unless idle)
//   fin        : inclusive bound per dim, dim d at [d*W +: W]
//   stride     : per-dim step, 0 treated as 1 (GET_CTRL_ND_STRIDE_EN only)
//   out_ready  : consumer takes current tuple
//   out_valid  : idx/last hold a valid tuple
//   idx, last  : current tuple and per-dim final-value flags
//   busy       : sweep in progress
//   done       : one-cycle pulse after final accept
// Optional feature macro: GET_CTRL_ND_STRIDE_EN (adds the stride input).
module get_ctrl_nd
  import get_pkg::*;
#(
  parameter int W    = GET_W,
  parameter int DIMS = GET_DIMS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIMS*W-1:0] fin,
`ifdef GET_CTRL_ND_STRIDE_EN
  input  logic [DIMS*W-1:0] stride,
`endif
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DIMS*W-1:0] idx,
  output logic [DIMS-1:0]   last,
  output logic              busy,
  output logic              done
);

  localparam logic [0:0] S_IDLE = IDLE;
  localparam logic [0:0] S_RUN  = RUN;

  logic [0:0]        r_state;
  logic [DIMS*W-1:0] r_fin;
  logic              r_done;

  logic [DIMS*W-1:0] w_step;
  logic [DIMS-1:0]   w_last;
  logic [DIMS:0]     w_carry;
  logic              w_start_ok;
  logic              w_accept;
  logic              w_final;

  assign w_start_ok = start && (r_state == S_IDLE);
  assign w_accept   = (r_state == S_RUN) && out_ready;

`ifdef GET_CTRL_ND_STRIDE_EN
  logic [DIMS*W-1:0] r_step;
  logic [DIMS*W-1:0] w_step_in;

  for (genvar d = 0; d < DIMS; d++) begin : g_step
    assign w_step_in[slice_lo(d, W) +: W] =
      (stride[slice_lo(d, W) +: W] == '0) ? W'(1) : stride[slice_lo(d, W) +: W];
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_step <= '0;
    else if (w_start_ok)
      r_step <= w_step_in;
  end

  assign w_step = r_step;
`else
  assign w_step = {DIMS{W'(1)}};
`endif

  // Ripple carry: dim d advances when every lower dim is at its last value.
  assign w_carry[0] = w_accept;
  for (genvar d = 0; d < DIMS; d++) begin : g_dim
    assign w_carry[d+1] = w_carry[d] && w_last[d];

    loop_cnt #(.W(W)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (w_start_ok),
      .inc   (w_carry[d]),
      .bound (r_fin[slice_lo(d, W) +: W]),
      .step  (w_step[slice_lo(d, W) +: W]),
      .value (idx[slice_lo(d, W) +: W]),
      .last  (w_last[d])
    );
  end

  // Carry out of the top dim means the final tuple was accepted; every
  // counter has wrapped to 0 in the same edge.
  assign w_final = w_carry[DIMS];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_fin   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_fin   <= fin;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_final) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_valid = (r_state == S_RUN);
  assign busy      = (r_state == S_RUN);
  assign done      = r_done;
  // Flags only mean something alongside a valid tuple.
  assign last      = w_last & {DIMS{out_valid}};

endmodule

// File: doc/get_ctrl_nd.md
Name: get_ctrl_nd

Overview:
Parametrised N-dimensional nested-loop address sequencer for the get path. It generalises the fixed 2-level i/j get controller to DIMS levels of width W. It adds a valid/ready handshake toward the consumer and emits a one-cycle completion pulse. It sits between the host-side get trigger and the memory-read / exec stage, and drives one index tuple per accepted beat.

Parameters:
W, 20, width of every loop index and bound.
DIMS, 3, number of nested loop levels (>=1); dim 0 is innermost.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  one-cycle request to begin a sweep; honoured only in IDLE
fin  in  DIMS*W  inclusive upper bound per dim, dim d at bits [d*W +: W]; sampled on accepted start
out_ready  in  1  consumer accepts the current tuple this cycle
out_valid  out  1  idx holds a valid tuple (exec-equivalent)
idx  out  DIMS*W  current index tuple, same packing as fin
last  out  DIMS  last[d]=1 when dim d is at its final value in the current tuple
busy  out  1  high in RUN
done  out  1  one-cycle pulse after the final tuple is accepted

Behaviour:
- Reset: state=IDLE; out_valid=0, idx=0, last=0, busy=0, done=0; latched bounds=0. Reset mid-sweep aborts immediately and emits no done pulse.
- States: IDLE, RUN.
- IDLE -> RUN: start=1 latches fin (and stride, if enabled). Next cycle: idx=all zero, out_valid=1, busy=1. Latency start->first valid = 1 cycle.
- RUN beat: a tuple is accepted when out_valid & out_ready. With out_ready=0, idx, last and out_valid hold unchanged; no tuple is lost or repeated.
- Advance on accept: dim 0 increments. If last[d] and all lower dims are last, dim d wraps to 0 and dim d+1 increments (ripple carry in the same cycle).
- last[d]: idx_d + step_d > fin_d, computed in W+1 bits so there is no overflow at fin_d = 2^W-1. step_d = 1 without the feature.
- Final tuple: all last[d]=1 and accepted -> next cycle out_valid=0, busy=0, done=1 for exactly one cycle, state=IDLE, idx returns to 0.
- A start while in RUN, or in the same cycle as the final accept, is ignored. start may be accepted in the cycle done is high; done and the new first valid then follow normally.
- fin_d=0: the dim has a single value and last[d] is constant 1. All fin=0 gives exactly one tuple.
- Total tuples = product over d of (floor(fin_d/step_d)+1).
- Throughput: 1 tuple/cycle with out_ready tied high.

Optional Feature:
Macro GET_CTRL_ND_STRIDE_EN. When defined, the block adds input stride (DIMS*W, same packing), latched with fin on accepted start. Dim d advances by stride_d, and a latched stride of 0 is treated as 1. Indices never exceed fin_d; the last value is the largest k*stride_d <= fin_d. When undefined, the port is absent and every step is 1.

Decomposition:
- Package get_pkg: parameter defaults (GET_W=20, GET_DIMS=3), state enum {IDLE, RUN}, and a pack/unpack helper function for the d*W slicing.
- Sub-module loop_cnt: a single-dim counter with inputs clr, inc, bound and step, and outputs value and last.
- get_ctrl_nd instantiates DIMS loop_cnt via generate and chains the carry (inc_d = accept & AND of last[0..d-1]).

Test Plan:
- DIMS=2, fin={2,3}, out_ready=1, single start -> 12 tuples (0,0)..(2,3) on consecutive cycles, inner dim fastest. last[0] high on j=3 tuples. done pulses 1 cycle after the (2,3) accept.
- All fin=0, start -> exactly one tuple (0,0,0) with last=3'b111, then done; out_valid high for 1 cycle.
- fin={1,1}, out_ready toggling 1,0,0,1,... -> idx stable while ready=0. Sequence (0,0),(0,1),(1,0),(1,1) with no skips or duplicates; done only after the 4th accept.
- Second start pulsed mid-sweep, then start asserted in the done cycle -> the mid-sweep start is ignored. The new sweep's first valid appears the cycle after done.
- rst asserted at tuple 5 of 12 -> the next cycle shows out_valid=0, idx=0, busy=0, and done never pulses. A subsequent start runs a full clean sweep.
- STRIDE_EN, DIMS=1, fin=10, stride=3 -> tuples 0,3,6,9 with last on 9, then done. With stride=0 latched -> 0..10 in steps of 1. With W=20, fin=0xFFFFF, stride=0x80000 -> tuples 0, 0x80000, then last, with no wrap.
